// File: rtl/inst_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into words and
// writes them to instruction RAM at consecutive addresses, holding the core until done.
module inst_loader #(
  parameter int unsigned     w         = 32,
  parameter int unsigned     MAX_WORDS = 2048,
  parameter logic [w-1:0]    BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         is_write,
  output logic [w-1:0] im_addr,
  output logic [w-1:0] im_inst,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [w-1:0] words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]   state_q, state_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [w-1:0] shift_q, shift_d;
  logic [w-1:0] len_q, len_d;
  logic [w-1:0] idx_q, idx_d;
  logic [w-1:0] words_q, words_d;
  logic         is_write_q, is_write_d;
  logic [w-1:0] addr_q, addr_d;
  logic [w-1:0] inst_q, inst_d;

  logic         take;
  logic [w-1:0] shift_in;
  logic [w-1:0] idx_inc;

  assign rx_ready = (state_q == S_LEN) || (state_q == S_DATA);
  assign take     = rx_valid && rx_ready;
  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign shift_in = {rx_data, shift_q[w-1:8]};
  assign idx_inc  = idx_q + w'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    idx_d      = idx_q;
    words_d    = words_q;
    is_write_d = 1'b0;
    addr_d     = addr_q;
    inst_d     = inst_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          idx_d      = '0;
          words_d    = '0;
        end
      end
      S_LEN: begin
        if (take) begin
          shift_d    = shift_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d = shift_in;
            if ((shift_in == '0) || (shift_in > w'(MAX_WORDS))) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (take) begin
          shift_d    = shift_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            is_write_d = 1'b1;
            addr_d     = BASE_ADDR + (idx_q << 2);
            inst_d     = shift_in;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        words_d = words_q + w'(1);
        state_d = (idx_inc == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      words_q    <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
    end
  end

  assign is_write     = is_write_q;
  assign im_addr      = addr_q;
  assign im_inst      = inst_q;
  assign busy         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign core_hold    = (state_q != S_DONE);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: frames are built from word lists and every RAM
// write is matched against an expected (address, word) queue.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, is_write, core_hold, busy, done, error;
  logic [31:0] im_addr, im_inst, words_loaded;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] frame_q[$];
  logic [31:0] m_addr, m_inst;

  always #5 clk = ~clk;

  inst_loader #(.w(32), .MAX_WORDS(2048), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  // Every write strobe must match the next expected write, with no byte accepted that cycle.
  always @(negedge clk) begin
    if (is_write === 1'b1) begin
      vectors++;
      if (exp_addr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h inst=%h (no write expected)", im_addr, im_inst);
      end else begin
        m_addr = exp_addr_q.pop_front();
        m_inst = exp_inst_q.pop_front();
        if (im_addr !== m_addr || im_inst !== m_inst) begin
          miscompares++;
          $display("FAIL write_data addr=%h inst=%h expected addr=%h inst=%h",
                   im_addr, im_inst, m_addr, m_inst);
        end
      end
      vectors++;
      if (rx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write rx_ready=%b expected 0", rx_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL byte_timeout rx_ready=%b expected 1 within 100 cycles", rx_ready);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] wd, input int gap_lo, input int gap_hi);
    for (int i = 0; i < 4; i++)
      send_byte(wd[8*i +: 8], $urandom_range(gap_hi, gap_lo));
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends header + frame_q payload; expected writes go to consecutive word addresses.
  task automatic load_frame(input int gap_lo, input int gap_hi, input bit poke_start);
    logic [31:0] n;
    n = 32'(frame_q.size());
    foreach (frame_q[i]) begin
      exp_addr_q.push_back(32'(i) * 32'd4);
      exp_inst_q.push_back(frame_q[i]);
    end
    send_word(n, gap_lo, gap_hi);
    foreach (frame_q[i]) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(frame_q[i][8*b +: 8], $urandom_range(gap_hi, gap_lo));
        if (poke_start && b == 1) start_pulse();
      end
      @(negedge clk);
      vectors++;
      if (is_write !== 1'b1) begin
        miscompares++;
        $display("FAIL write_latency word=%0d is_write=%b expected 1", i, is_write);
      end
      if (i == frame_q.size() - 1) begin
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || core_hold !== 1'b0) begin
          miscompares++;
          $display("FAIL done_latency done=%b core_hold=%b expected 1/0", done, core_hold);
        end
      end
    end
  endtask

  task automatic check_done(input int exp_words);
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || core_hold !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state done=%b error=%b hold=%b busy=%b rdy=%b expected 1/0/0/0/0",
               done, error, core_hold, busy, rx_ready);
    end
    vectors++;
    if (words_loaded !== 32'(exp_words) || exp_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL words_loaded got=%0d expected=%0d missing_writes=%0d",
               words_loaded, exp_words, exp_addr_q.size());
    end
  endtask

  task automatic check_error();
    int n;
    n = 0;
    while (error !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL error_state error=%b done=%b hold=%b busy=%b rdy=%b expected 1/0/1/0/0",
               error, done, core_hold, busy, rx_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (rx_ready !== 1'b0 || is_write !== 1'b0 || im_addr !== 32'h0 || im_inst !== 32'h0 ||
        core_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        words_loaded !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values rdy=%b wr=%b addr=%h inst=%h hold=%b busy=%b done=%b err=%b words=%0d",
               rx_ready, is_write, im_addr, im_inst, core_hold, busy, done, error, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rx_ready !== 1'b0 || is_write !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset busy=%b rdy=%b wr=%b expected 0/0/0", busy, rx_ready, is_write);
    end
  endtask

  task automatic test_basic(input int gap);
    start_pulse();
    vectors++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || core_hold !== 1'b1 || words_loaded !== 32'h0) begin
      miscompares++;
      $display("FAIL start_state busy=%b rdy=%b hold=%b words=%0d expected 1/1/1/0",
               busy, rx_ready, core_hold, words_loaded);
    end
    frame_q = '{32'h0010_0513, 32'h0020_0593};
    load_frame(gap, gap, 1'b0);
    check_done(2);
  endtask

  task automatic test_bad_header(input logic [31:0] n);
    start_pulse();
    send_word(n, 0, 1);
    check_error();
    @(negedge clk);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL err_no_accept rx_ready=%b error=%b expected 0/1", rx_ready, error);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_recover_after_error();
    start_pulse();
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL error_clear error=%b busy=%b expected 0/1", error, busy);
    end
    frame_q = '{32'($urandom)};
    load_frame(0, 2, 1'b0);
    check_done(1);
  endtask

  task automatic test_mid_word_reset();
    start_pulse();
    send_word(32'd2, 0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    test_reset();
    vectors++;
    if (exp_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_queue pending=%0d expected 0", exp_addr_q.size());
    end
    start_pulse();
    frame_q = '{32'($urandom), 32'($urandom)};
    load_frame(0, 1, 1'b0);
    check_done(2);
  endtask

  task automatic test_start_ignored();
    start_pulse();
    frame_q = '{32'($urandom), 32'($urandom), 32'($urandom)};
    load_frame(0, 1, 1'b1);
    check_done(3);
  endtask

  task automatic test_second_load();
    start_pulse();
    vectors++;
    if (core_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 32'h0) begin
      miscompares++;
      $display("FAIL reload_state hold=%b done=%b words=%0d expected 1/0/0", core_hold, done, words_loaded);
    end
    frame_q = '{32'hDEAD_BEEF};
    load_frame(0, 0, 1'b0);
    check_done(1);
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 6; f++) begin
      start_pulse();
      n = $urandom_range(8, 1);
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(32'($urandom));
      load_frame(0, 3, 1'b0);
      check_done(n);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic(0);
    test_basic(3);
    test_bad_header(32'h0000_0000);
    test_recover_after_error();
    test_bad_header(32'h0000_0801);
    test_bad_header(32'h0100_0001);
    test_recover_after_error();
    test_mid_word_reset();
    test_start_ignored();
    test_second_load();
    test_random_frames();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
